// File: rtl/front_panel_loader.sv
// PDP-8 front-panel responder: conditions buttons and the run switch,
// then issues CPU load/step strobes or deposit writes with auto-increment.
module front_panel_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MEM_TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic [12:0] sw,
  input  logic        btnc,
  input  logic        btnu,
  input  logic        btnd,
  input  logic        btnl,
  input  logic        btnr,
  input  logic        cpu_idle,
  input  logic [11:0] pc_in,
  input  logic [11:0] ac_in,
  input  logic        mem_finished,
  output logic [11:0] address,
  output logic [11:0] write_data,
  output logic        write_enable,
  output logic        load_pc,
  output logic [11:0] pc_value,
  output logic        load_ac,
  output logic [11:0] ac_value,
  output logic        step_req,
  output logic        run,
  output logic        busy,
  output logic        mem_error,
  output logic [11:0] disp_value
);

  localparam int NB = 6;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    FP_IDLE,
    FP_WRITE
  } fp_state_t;

  // bit order: 0 disp, 1 step, 2 deposit, 3 load pc, 4 load ac, 5 run
  logic [NB-1:0]         raw;
  logic [NB-1:0]         s1;
  logic [NB-1:0]         s2;
  logic [NB-1:0]         deb;
  logic [NB-1:0]         deb_q;
  logic [NB-1:0]         rise;
  logic [NB-1:0][CW-1:0] cnt;

  fp_state_t   state;
  fp_state_t   state_n;
  logic [11:0] ptr;
  logic [TW-1:0] tmo;
  logic        disp_sel;

  logic do_lpc;
  logic do_lac;
  logic do_step;
  logic do_dep;
  logic wr_done;
  logic wr_abort;

  assign raw  = {sw[12], btnr, btnl, btnd, btnu, btnc};
  assign rise = deb & ~deb_q;
  assign run  = deb[5] && (state == FP_IDLE);
  assign disp_value = disp_sel ? ac_in : pc_in;

  always_ff @(posedge clk) begin
    if (!btnCpuReset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_q <= '0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_q <= deb;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] != deb[i]) begin
          if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i] <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    state_n  = state;
    do_lpc   = 1'b0;
    do_lac   = 1'b0;
    do_step  = 1'b0;
    do_dep   = 1'b0;
    wr_done  = 1'b0;
    wr_abort = 1'b0;
    unique case (state)
      FP_IDLE: begin
        if (!run) begin
          if (rise[3]) begin
            do_lpc = 1'b1;
          end else if (rise[2]) begin
            do_dep  = 1'b1;
            state_n = FP_WRITE;
          end else if (rise[4]) begin
            do_lac = 1'b1;
          end else if (rise[1] && cpu_idle) begin
            do_step = 1'b1;
          end
        end
      end
      FP_WRITE: begin
        if (mem_finished) begin
          wr_done = 1'b1;
          state_n = FP_IDLE;
        end else if (tmo == TW'(MEM_TIMEOUT - 1)) begin
          wr_abort = 1'b1;
          state_n  = FP_IDLE;
        end
      end
      default: state_n = FP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!btnCpuReset) begin
      state        <= FP_IDLE;
      ptr          <= '0;
      tmo          <= '0;
      disp_sel     <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      mem_error    <= 1'b0;
      load_pc      <= 1'b0;
      pc_value     <= '0;
      load_ac      <= 1'b0;
      ac_value     <= '0;
      step_req     <= 1'b0;
    end else begin
      state    <= state_n;
      load_pc  <= do_lpc;
      load_ac  <= do_lac;
      step_req <= do_step;
      tmo      <= (state == FP_WRITE) ? tmo + 1'b1 : '0;
      if (rise[0] && state == FP_IDLE)
        disp_sel <= ~disp_sel;
      if (do_lpc) begin
        pc_value <= sw[11:0];
        ptr      <= sw[11:0];
      end
      if (do_lac)
        ac_value <= sw[11:0];
      if (do_dep) begin
        write_enable <= 1'b1;
        busy         <= 1'b1;
        address      <= ptr;
        write_data   <= sw[11:0];
      end
      if (wr_done) begin
        write_enable <= 1'b0;
        busy         <= 1'b0;
        ptr          <= ptr + 12'd1;
      end
      // an aborted write keeps the pointer so the next deposit retries it
      if (wr_abort) begin
        write_enable <= 1'b0;
        busy         <= 1'b0;
        mem_error    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_front_panel_loader.sv
// Scoreboard bench for front_panel_loader: directed presses push expected
// strobes/writes, a negedge monitor pops and compares them.
module tb_front_panel_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] sw = '0;
  logic        btnc = 0, btnu = 0, btnd = 0, btnl = 0, btnr = 0;
  logic        cpu_idle = 1'b0;
  logic [11:0] pc_in = 12'o1111;
  logic [11:0] ac_in = 12'o2222;
  logic        mem_finished = 1'b0;
  logic [11:0] address, write_data, pc_value, ac_value, disp_value;
  logic        write_enable, load_pc, load_ac, step_req;
  logic        run, busy, mem_error;

  front_panel_loader dut (
    .clk(clk), .btnCpuReset(rst_n), .sw(sw),
    .btnc(btnc), .btnu(btnu), .btnd(btnd), .btnl(btnl), .btnr(btnr),
    .cpu_idle(cpu_idle), .pc_in(pc_in), .ac_in(ac_in),
    .mem_finished(mem_finished), .address(address),
    .write_data(write_data), .write_enable(write_enable),
    .load_pc(load_pc), .pc_value(pc_value), .load_ac(load_ac),
    .ac_value(ac_value), .step_req(step_req), .run(run),
    .busy(busy), .mem_error(mem_error), .disp_value(disp_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [11:0] val;
    logic [11:0] addr;
  } ev_t;

  localparam int K_LPC = 1, K_LAC = 2, K_STEP = 3, K_WR = 4;

  ev_t q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  mem_delay = 3;
  bit  mem_on = 1'b1;
  logic we_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [11:0] v,
                      input logic [11:0] a);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.addr = a;
    q.push_back(e);
  endtask

  task automatic got(input string name, input int k,
                     input logic [11:0] v, input logic [11:0] a);
    ev_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event val=%0o addr=%0o", name, v, a);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.val !== v || e.addr !== a) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d val=%0o addr=%0o expected kind=%0d val=%0o addr=%0o",
                 name, k, v, a, e.kind, e.val, e.addr);
      end
    end
  endtask

  // monitor
  initial forever begin
    @(negedge clk);
    if (load_pc) got("load_pc", K_LPC, pc_value, 12'o0);
    if (load_ac) got("load_ac", K_LAC, ac_value, 12'o0);
    if (step_req) got("step_req", K_STEP, 12'o0, 12'o0);
    if (write_enable && !we_prev) begin
      got("write", K_WR, write_data, address);
      chk("busy_on_write", int'(busy), 1);
    end
    if (!write_enable && we_prev)
      chk("busy_on_drop", int'(busy), 0);
    we_prev = write_enable;
  end

  // memory model
  initial begin
    int wc = 0;
    forever begin
      @(negedge clk);
      if (write_enable && mem_on && !mem_finished) begin
        wc++;
        mem_finished = (wc == mem_delay);
      end else begin
        wc = 0;
        mem_finished = 1'b0;
      end
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btnc = v;
      1: btnu = v;
      2: btnd = v;
      3: btnl = v;
      default: btnr = v;
    endcase
  endtask

  task automatic press(input int b);
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (10) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", int'(busy), 0);
  endtask

  task automatic wait_we();
    int n = 0;
    while (!write_enable && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("we_start", int'(write_enable), 1);
  endtask

  task automatic deposit(input logic [11:0] d, input logic [11:0] a);
    sw[11:0] = d;
    push(K_WR, d, a);
    press(2);
    wait_idle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_we", int'(write_enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_run", int'(run), 0);
    chk("rst_err", int'(mem_error), 0);
    chk("rst_addr", int'(address), 0);
    chk("rst_disp", int'(disp_value), int'(pc_in));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // load pc latency: strobe after 7th edge
    sw[11:0] = 12'o0200;
    push(K_LPC, 12'o0200, 12'o0);
    btnl = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("lpc_early", int'(load_pc), 0);
    @(posedge clk);
    #1 chk("lpc_on_time", int'(load_pc), 1);
    repeat (10) @(negedge clk);
    btnl = 1'b0;
    repeat (10) @(negedge clk);

    // deposits with wrap
    sw[11:0] = 12'o7776;
    push(K_LPC, 12'o7776, 12'o0);
    press(3);
    deposit(12'o1234, 12'o7776);
    deposit(12'o4321, 12'o7777);
    deposit(12'o5555, 12'o0000);

    // timeout and retry at same address
    mem_on = 1'b0;
    sw[11:0] = 12'o1111;
    push(K_WR, 12'o1111, 12'o0001);
    @(negedge clk);
    btnd = 1'b1;
    wait_we();
    btnd = 1'b0;
    n = 0;
    while (write_enable && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_len", n, 64);
    chk("mem_error", int'(mem_error), 1);
    repeat (10) @(negedge clk);
    mem_on = 1'b1;
    deposit(12'o2222, 12'o0001);
    chk("err_sticky", int'(mem_error), 1);

    // glitch ignored
    @(negedge clk);
    btnd = 1'b1;
    repeat (2) @(negedge clk);
    btnd = 1'b0;
    repeat (15) @(negedge clk);
    chk("glitch_busy", int'(busy), 0);

    // simultaneous load pc + load ac
    sw[11:0] = 12'o0040;
    push(K_LPC, 12'o0040, 12'o0);
    @(negedge clk);
    btnl = 1'b1;
    btnr = 1'b1;
    repeat (10) @(negedge clk);
    btnl = 1'b0;
    btnr = 1'b0;
    repeat (10) @(negedge clk);

    // run held off by an active deposit
    mem_delay = 20;
    sw[11:0] = 12'o0777;
    push(K_WR, 12'o0777, 12'o0040);
    @(negedge clk);
    btnd = 1'b1;
    wait_we();
    btnd = 1'b0;
    sw[12] = 1'b1;
    repeat (10) @(negedge clk);
    chk("run_held", int'(run), 0);
    wait_idle();
    chk("run_after", int'(run), 1);
    mem_delay = 3;

    // with run: step dropped, display toggles
    cpu_idle = 1'b1;
    press(1);
    chk("disp_pc", int'(disp_value), int'(pc_in));
    press(0);
    chk("disp_ac", int'(disp_value), int'(ac_in));
    sw[12] = 1'b0;
    repeat (10) @(negedge clk);
    chk("run_off", int'(run), 0);

    // step and load ac
    cpu_idle = 1'b0;
    press(1);
    cpu_idle = 1'b1;
    push(K_STEP, 12'o0, 12'o0);
    press(1);
    sw[11:0] = 12'o0321;
    push(K_LAC, 12'o0321, 12'o0);
    press(4);

    // reset mid-write, then pointer restarts at 0
    mem_on = 1'b0;
    sw[11:0] = 12'o0555;
    push(K_WR, 12'o0555, 12'o0041);
    @(negedge clk);
    btnd = 1'b1;
    wait_we();
    btnd = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_we", int'(write_enable), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_err", int'(mem_error), 0);
    chk("rst_mid_addr", int'(address), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_on = 1'b1;
    repeat (10) @(negedge clk);
    deposit(12'o3333, 12'o0000);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
